// File: rtl/snoop_responder_d_1_pkg.sv
// Shared constants and encodings for the bus snoop responder.
// Holds cache geometry, MESI/snoop command encodings and the FSM state type.
package snoop_responder_d_1_pkg;

    localparam int ADDRESSSIZE     = 32;
    localparam int BLK_OFFSET_SIZE = 6;
    localparam int INDEX_SIZE      = 4;
    localparam int TAG_SIZE        = 22;
    localparam int ASSOCIATIVITY   = 4;
    localparam int WAY_BITS        = 2;
    localparam int NUM_SETS        = 1 << INDEX_SIZE;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_e;

    typedef enum logic [1:0] {
        CMD_BUSRD   = 2'b00,
        CMD_BUSRDX  = 2'b01,
        CMD_BUSUPGR = 2'b10,
        CMD_RSVD    = 2'b11
    } snoop_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_RESPOND,
        ST_FLUSH,
        ST_UPDATE
    } fsm_e;

    // MESI transition for a snooped hit; the reserved command leaves the line alone.
    function automatic logic [1:0] mesi_next(input logic [1:0] cmd, input logic [1:0] state);
        logic [1:0] result;
        result = state;
        case (cmd)
            CMD_BUSRD:               if (state != MESI_I) result = MESI_S;
            CMD_BUSRDX, CMD_BUSUPGR: result = MESI_I;
            default:                 result = state;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/snoop_tag_state_array_d_1.sv
// 16-set x 4-way tag/state store with a registered snoop lookup port, a
// combinational processor read port and two write ports (snoop has priority).
module snoop_tag_state_array_d_1
    import snoop_responder_d_1_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lk_en,
    input  logic [INDEX_SIZE-1:0] lk_index,
    input  logic [TAG_SIZE-1:0]   lk_tag,
    output logic                  lk_hit,
    output logic [WAY_BITS-1:0]   lk_way,
    output logic [1:0]            lk_state,
    input  logic [INDEX_SIZE-1:0] rd_index,
    input  logic [WAY_BITS-1:0]   rd_way,
    output logic [1:0]            rd_state,
    input  logic                  sn_wr_en,
    input  logic [INDEX_SIZE-1:0] sn_wr_index,
    input  logic [WAY_BITS-1:0]   sn_wr_way,
    input  logic [1:0]            sn_wr_state,
    input  logic                  pr_wr_en,
    input  logic [INDEX_SIZE-1:0] pr_wr_index,
    input  logic [WAY_BITS-1:0]   pr_wr_way,
    input  logic [TAG_SIZE-1:0]   pr_wr_tag,
    input  logic [1:0]            pr_wr_state,
    output logic                  pr_wr_conflict
);

    logic [TAG_SIZE-1:0]      tag_mem   [NUM_SETS][ASSOCIATIVITY];
    logic [1:0]               state_mem [NUM_SETS][ASSOCIATIVITY];
    logic [ASSOCIATIVITY-1:0] way_match;
    logic [WAY_BITS-1:0]      hit_way_next;
    logic                     hit_next;
    logic [1:0]               hit_state_next;
    logic                     lk_hit_reg;
    logic [WAY_BITS-1:0]      lk_way_reg;
    logic [1:0]               lk_state_reg;
    logic                     pr_wr_go;

    genvar gi;
    generate
        for (gi = 0; gi < ASSOCIATIVITY; gi++) begin : g_way_cmp
            assign way_match[gi] = (state_mem[lk_index][gi] != MESI_I) &&
                                   (tag_mem[lk_index][gi] == lk_tag);
        end
    endgenerate

    // Lowest matching way wins when a tag is (illegally) present in several ways.
    always_comb begin
        hit_way_next = '0;
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (way_match[w]) hit_way_next = w[WAY_BITS-1:0];
        end
    end

    assign hit_next       = |way_match;
    assign hit_state_next = hit_next ? state_mem[lk_index][hit_way_next] : MESI_I;

    // A processor install colliding with the snoop commit is dropped entirely (tag too).
    assign pr_wr_conflict = pr_wr_en && sn_wr_en &&
                            (pr_wr_index == sn_wr_index) && (pr_wr_way == sn_wr_way);
    assign pr_wr_go       = pr_wr_en && !pr_wr_conflict;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < ASSOCIATIVITY; w++) begin
                    tag_mem[s][w]   <= '0;
                    state_mem[s][w] <= MESI_I;
                end
            end
            lk_hit_reg   <= 1'b0;
            lk_way_reg   <= '0;
            lk_state_reg <= MESI_I;
        end else begin
            if (pr_wr_go) begin
                tag_mem[pr_wr_index][pr_wr_way]   <= pr_wr_tag;
                state_mem[pr_wr_index][pr_wr_way] <= pr_wr_state;
            end
            if (sn_wr_en) begin
                state_mem[sn_wr_index][sn_wr_way] <= sn_wr_state;
            end
            if (lk_en) begin
                lk_hit_reg   <= hit_next;
                lk_way_reg   <= hit_way_next;
                lk_state_reg <= hit_state_next;
            end
        end
    end

    assign lk_hit   = lk_hit_reg;
    assign lk_way   = lk_way_reg;
    assign lk_state = lk_state_reg;
    assign rd_state = state_mem[rd_index][rd_way];

endmodule

// File: rtl/snoop_responder_d_1.sv
// MESI bus snoop responder: looks up a snooped line, reports shared/dirty,
// optionally waits for a write-back, then commits the next coherence state.
module snoop_responder_d_1
    import snoop_responder_d_1_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   snoop_valid,
    output logic                   snoop_ready,
    input  logic [1:0]             snoop_cmd,
    input  logic [ADDRESSSIZE-1:0] Address_Com,
    output logic                   snoop_resp_valid,
    output logic                   Shared_Com,
    output logic                   Dirty_Com,
    output logic                   flush_req,
    output logic [INDEX_SIZE-1:0]  flush_index,
    output logic [WAY_BITS-1:0]    flush_way,
    input  logic                   flush_ack,
    output logic                   snoop_done,
    output logic                   protocol_err,
    input  logic                   proc_wr_en,
    input  logic [INDEX_SIZE-1:0]  proc_wr_index,
    input  logic [WAY_BITS-1:0]    proc_wr_way,
    input  logic [TAG_SIZE-1:0]    proc_wr_tag,
    input  logic [1:0]             proc_wr_state,
    input  logic [INDEX_SIZE-1:0]  proc_rd_index,
    input  logic [WAY_BITS-1:0]    proc_rd_way,
    output logic [1:0]             proc_rd_state,
    output logic                   proc_wr_conflict
);

    fsm_e                  state_reg;
    logic [1:0]            cmd_reg;
    logic [INDEX_SIZE-1:0] index_reg;
    logic [TAG_SIZE-1:0]   tag_reg;
    logic                  resp_valid_reg;
    logic                  flush_req_reg;
    logic                  done_reg;
    logic                  perr_reg;

    logic                  lk_hit;
    logic [WAY_BITS-1:0]   lk_way;
    logic [1:0]            lk_state;
    logic                  line_dirty;
    logic                  needs_flush;
    logic                  upgr_err;
    logic                  snoop_wr_en;
    logic                  unused_offset;

    assign unused_offset = ^Address_Com[BLK_OFFSET_SIZE-1:0];

    assign line_dirty  = lk_hit && (lk_state == MESI_M);
    assign needs_flush = line_dirty && ((cmd_reg == CMD_BUSRD) || (cmd_reg == CMD_BUSRDX));
    assign upgr_err    = lk_hit && (cmd_reg == CMD_BUSUPGR) &&
                         ((lk_state == MESI_E) || (lk_state == MESI_M));
    // Commit uses the state captured at lookup, not whatever the processor wrote since.
    assign snoop_wr_en = !rst && (state_reg == ST_UPDATE) && lk_hit && (cmd_reg != CMD_RSVD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cmd_reg        <= '0;
            index_reg      <= '0;
            tag_reg        <= '0;
            resp_valid_reg <= 1'b0;
            flush_req_reg  <= 1'b0;
            done_reg       <= 1'b0;
            perr_reg       <= 1'b0;
        end else begin
            resp_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
            perr_reg       <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (snoop_valid) begin
                        cmd_reg   <= snoop_cmd;
                        index_reg <= Address_Com[BLK_OFFSET_SIZE +: INDEX_SIZE];
                        tag_reg   <= Address_Com[ADDRESSSIZE-1 -: TAG_SIZE];
                        state_reg <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    resp_valid_reg <= 1'b1;
                    state_reg      <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    if (needs_flush) begin
                        flush_req_reg <= 1'b1;
                        state_reg     <= ST_FLUSH;
                    end else begin
                        done_reg  <= 1'b1;
                        perr_reg  <= upgr_err;
                        state_reg <= ST_UPDATE;
                    end
                end
                ST_FLUSH: begin
                    if (flush_ack) begin
                        flush_req_reg <= 1'b0;
                        done_reg      <= 1'b1;
                        perr_reg      <= upgr_err;
                        state_reg     <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    snoop_tag_state_array_d_1 u_array (
        .clk            (clk),
        .rst            (rst),
        .lk_en          (state_reg == ST_LOOKUP),
        .lk_index       (index_reg),
        .lk_tag         (tag_reg),
        .lk_hit         (lk_hit),
        .lk_way         (lk_way),
        .lk_state       (lk_state),
        .rd_index       (proc_rd_index),
        .rd_way         (proc_rd_way),
        .rd_state       (proc_rd_state),
        .sn_wr_en       (snoop_wr_en),
        .sn_wr_index    (index_reg),
        .sn_wr_way      (lk_way),
        .sn_wr_state    (mesi_next(cmd_reg, lk_state)),
        .pr_wr_en       (proc_wr_en),
        .pr_wr_index    (proc_wr_index),
        .pr_wr_way      (proc_wr_way),
        .pr_wr_tag      (proc_wr_tag),
        .pr_wr_state    (proc_wr_state),
        .pr_wr_conflict (proc_wr_conflict)
    );

    assign snoop_ready      = (state_reg == ST_IDLE);
    assign snoop_resp_valid = resp_valid_reg;
    assign Shared_Com       = resp_valid_reg && lk_hit;
    assign Dirty_Com        = resp_valid_reg && line_dirty;
    assign flush_req        = flush_req_reg;
    assign flush_index      = flush_req_reg ? index_reg : '0;
    assign flush_way        = flush_req_reg ? lk_way : '0;
    assign snoop_done       = done_reg;
    assign protocol_err     = perr_reg;

endmodule

// File: tb/tb_snoop_responder_d_1.sv
// Randomized bench for snoop_responder_d_1 against a behavioural MESI cache model.
module tb_snoop_responder_d_1;

    logic        clk = 1'b0;
    logic        rst;
    logic        snoop_valid;
    logic        snoop_ready;
    logic [1:0]  snoop_cmd;
    logic [31:0] Address_Com;
    logic        snoop_resp_valid;
    logic        Shared_Com;
    logic        Dirty_Com;
    logic        flush_req;
    logic [3:0]  flush_index;
    logic [1:0]  flush_way;
    logic        flush_ack;
    logic        snoop_done;
    logic        protocol_err;
    logic        proc_wr_en;
    logic [3:0]  proc_wr_index;
    logic [1:0]  proc_wr_way;
    logic [21:0] proc_wr_tag;
    logic [1:0]  proc_wr_state;
    logic [3:0]  proc_rd_index;
    logic [1:0]  proc_rd_way;
    logic [1:0]  proc_rd_state;
    logic        proc_wr_conflict;

    int checks = 0;
    int errors = 0;

    // Reference cache contents: state 0=I 1=S 2=E 3=M
    logic [1:0]  m_state [16][4];
    logic [21:0] m_tag   [16][4];

    always #5 clk = ~clk;

    snoop_responder_d_1 dut (
        .clk              (clk),
        .rst              (rst),
        .snoop_valid      (snoop_valid),
        .snoop_ready      (snoop_ready),
        .snoop_cmd        (snoop_cmd),
        .Address_Com      (Address_Com),
        .snoop_resp_valid (snoop_resp_valid),
        .Shared_Com       (Shared_Com),
        .Dirty_Com        (Dirty_Com),
        .flush_req        (flush_req),
        .flush_index      (flush_index),
        .flush_way        (flush_way),
        .flush_ack        (flush_ack),
        .snoop_done       (snoop_done),
        .protocol_err     (protocol_err),
        .proc_wr_en       (proc_wr_en),
        .proc_wr_index    (proc_wr_index),
        .proc_wr_way      (proc_wr_way),
        .proc_wr_tag      (proc_wr_tag),
        .proc_wr_state    (proc_wr_state),
        .proc_rd_index    (proc_rd_index),
        .proc_rd_way      (proc_rd_way),
        .proc_rd_state    (proc_rd_state),
        .proc_wr_conflict (proc_wr_conflict)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_hit_way(input logic [3:0] idx, input logic [21:0] tag);
        for (int w = 0; w < 4; w++) begin
            if (m_state[idx][w] != 2'd0 && m_tag[idx][w] == tag) return w;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 4; w++) begin
                m_state[s][w] = 2'd0;
                m_tag[s][w]   = 22'd0;
            end
        end
    endtask

    task automatic check_all_invalid(input string tag);
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 4; w++) begin
                proc_rd_index = s[3:0];
                proc_rd_way   = w[1:0];
                #1;
                check(tag, proc_rd_state, 2'd0);
            end
        end
    endtask

    task automatic install(input logic [3:0] idx, input logic [1:0] way,
                           input logic [21:0] tag, input logic [1:0] st);
        proc_wr_en    = 1'b1;
        proc_wr_index = idx;
        proc_wr_way   = way;
        proc_wr_tag   = tag;
        proc_wr_state = st;
        #1;
        check("install_noconflict", proc_wr_conflict, 1'b0);
        @(negedge clk);
        proc_wr_en = 1'b0;
        m_state[idx][way] = st;
        m_tag[idx][way]   = tag;
        proc_rd_index = idx;
        proc_rd_way   = way;
        #1;
        check("install_rd", proc_rd_state, st);
        $display("install idx=%0d way=%0d tag=%0h st=%0d", idx, way, tag, st);
    endtask

    // One complete snoop; called at a negedge while the responder is idle.
    task automatic do_snoop(input logic [1:0] cmd, input logic [3:0] idx, input logic [21:0] tag,
                            input int ack_delay, input bit collide);
        int          w;
        bit          hit, dirty, flush, perr, exp_conf;
        logic [1:0]  st, nxt, chk_way;
        logic [21:0] ptag;
        w     = model_hit_way(idx, tag);
        hit   = (w >= 0);
        st    = hit ? m_state[idx][w] : 2'd0;
        dirty = hit && st == 2'd3;
        flush = dirty && (cmd == 2'd0 || cmd == 2'd1);
        perr  = hit && cmd == 2'd2 && st >= 2'd2;
        nxt   = st;
        if (hit) begin
            if (cmd == 2'd0) nxt = 2'd1;
            else if (cmd == 2'd1 || cmd == 2'd2) nxt = 2'd0;
        end
        chk_way  = hit ? w[1:0] : 2'($urandom);
        exp_conf = collide && hit && cmd != 2'd3;
        ptag     = 22'($urandom);

        check("idle_ready", snoop_ready, 1'b1);
        snoop_valid = 1'b1;
        snoop_cmd   = cmd;
        Address_Com = {tag, idx, 6'($urandom)};
        @(negedge clk);
        snoop_valid = 1'b0;
        snoop_cmd   = 2'($urandom);
        Address_Com = $urandom;
        flush_ack   = 1'($urandom);
        check("lookup_ready", snoop_ready, 1'b0);
        check("lookup_rv", snoop_resp_valid, 1'b0);
        check("lookup_shared", Shared_Com, 1'b0);
        @(negedge clk);
        flush_ack = 1'($urandom);
        check("resp_valid", snoop_resp_valid, 1'b1);
        check("resp_shared", Shared_Com, hit);
        check("resp_dirty", Dirty_Com, dirty);
        check("resp_done", snoop_done, 1'b0);
        if (flush) begin
            for (int i = 0; i < ack_delay; i++) begin
                @(negedge clk);
                flush_ack = (i == ack_delay - 1);
                check("flush_req", flush_req, 1'b1);
                check("flush_index", flush_index, idx);
                check("flush_way", flush_way, w[1:0]);
                check("flush_done", snoop_done, 1'b0);
                check("flush_rv", snoop_resp_valid, 1'b0);
            end
        end
        @(negedge clk);
        flush_ack = 1'b0;
        check("upd_done", snoop_done, 1'b1);
        check("upd_perr", protocol_err, perr);
        check("upd_flush", flush_req, 1'b0);
        check("upd_shared", Shared_Com, 1'b0);
        if (collide && hit) begin
            proc_wr_en    = 1'b1;
            proc_wr_index = idx;
            proc_wr_way   = w[1:0];
            proc_wr_tag   = ptag;
            proc_wr_state = 2'd1;
            #1;
            check("upd_conflict", proc_wr_conflict, exp_conf);
        end
        @(negedge clk);
        proc_wr_en = 1'b0;
        if (hit) begin
            if (collide && !exp_conf) begin
                m_state[idx][w] = 2'd1;
                m_tag[idx][w]   = ptag;
            end else begin
                m_state[idx][w] = nxt;
            end
        end
        check("back_ready", snoop_ready, 1'b1);
        check("back_done", snoop_done, 1'b0);
        check("back_perr", protocol_err, 1'b0);
        proc_rd_index = idx;
        proc_rd_way   = chk_way;
        #1;
        check("line_state", proc_rd_state, m_state[idx][chk_way]);
        $display("snoop cmd=%0d idx=%0d tag=%0h hit=%0d way=%0d st=%0d->%0d flush=%0d perr=%0d conf=%0d",
                 cmd, idx, tag, hit, w, st, m_state[idx][chk_way], flush, perr, exp_conf);
    endtask

    function automatic logic [21:0] pool_tag(input int k);
        logic [21:0] t;
        case (k)
            0:       t = 22'h1A5;
            1:       t = 22'h02B;
            default: t = 22'h3FFFFF;
        endcase
        return t;
    endfunction

    initial begin
        rst = 1'b1;
        snoop_valid = 1'b0; snoop_cmd = '0; Address_Com = '0; flush_ack = 1'b0;
        proc_wr_en = 1'b0; proc_wr_index = '0; proc_wr_way = '0; proc_wr_tag = '0;
        proc_wr_state = '0; proc_rd_index = '0; proc_rd_way = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_rv", snoop_resp_valid, 1'b0);
        check("rst_flush", flush_req, 1'b0);
        check("rst_done", snoop_done, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready", snoop_ready, 1'b1);
        check("rel_rv", snoop_resp_valid, 1'b0);
        check("rel_perr", protocol_err, 1'b0);
        check("rel_flush_idx", flush_index, 4'd0);
        check_all_invalid("rel_state_i");

        // Directed scenarios
        do_snoop(2'd0, 4'd3, 22'h1A5, 1, 1'b0);   // all-invalid set: miss
        install(4'd3, 2'd2, 22'h1A5, 2'd2);
        do_snoop(2'd0, 4'd3, 22'h1A5, 1, 1'b0);   // E -> S, shared
        install(4'd3, 2'd2, 22'h1A5, 2'd3);
        do_snoop(2'd1, 4'd3, 22'h1A5, 5, 1'b0);   // M flush with 5-cycle ack delay
        install(4'd3, 2'd2, 22'h1A5, 2'd2);
        do_snoop(2'd2, 4'd3, 22'h1A5, 1, 1'b0);   // BusUpgr on E: protocol error
        install(4'd3, 2'd2, 22'h1A5, 2'd2);
        do_snoop(2'd1, 4'd3, 22'h1A5, 1, 1'b1);   // collision with processor write
        install(4'd3, 2'd0, 22'h1A5, 2'd1);
        install(4'd3, 2'd1, 22'h1A5, 2'd3);
        do_snoop(2'd0, 4'd3, 22'h1A5, 2, 1'b0);   // duplicate tag: lowest way wins

        // Reset in the middle of a flush
        install(4'd5, 2'd1, 22'h02B, 2'd3);
        snoop_valid = 1'b1; snoop_cmd = 2'd0; Address_Com = {22'h02B, 4'd5, 6'd0};
        @(negedge clk);
        snoop_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_flush_req", flush_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_flush", flush_req, 1'b0);
        check("abort_done", snoop_done, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", snoop_ready, 1'b1);
        check("abort_done2", snoop_done, 1'b0);
        model_reset();
        check_all_invalid("abort_state_i");
        $display("reset during flush");

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            logic [3:0]  idx;
            logic [21:0] tag;
            idx = ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
            tag = pool_tag($urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0)
                install(idx, 2'($urandom), tag, 2'($urandom));
            else
                do_snoop(2'($urandom), idx, tag, $urandom_range(1, 4), $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
